// File: rtl/bus_pkg.sv
// Shared bus definitions: master-port state encoding and the arbiter's
// "no master" ID.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    OWN     = 3'd2,
    RELEASE = 3'd3,
    SPLIT   = 3'd4
  } bm_state_t;

  localparam logic [3:0] MID_NONE = 4'b1111;

endpackage

// File: rtl/bus_timeout_ctr.sv
// Request timeout counter.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   load      - clear the count
//   en        - count one cycle
//   expire_c  - combinational flag: count has reached LIMIT
// The count saturates at LIMIT.
module bus_timeout_ctr #(
  parameter int unsigned LIMIT = 1024,
  parameter int unsigned CW    = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire_c
);

  logic [CW-1:0] count;

  assign expire_c = (count == CW'(LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !expire_c) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/bus_master_port.sv
// Master-side endpoint of the split-transaction arbitration handshake.
// Converts a core request into m_req/bus_util signalling, treats grant
// removal during ownership as a split and retakes the bus on re-grant.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   m_grant       - grant from the arbiter
//   m_req         - request to the arbiter
//   bus_util      - bus-in-use (wired-OR outside), high only while owning
//   core_req      - core wants the bus (level)
//   core_done     - core finished its transfer (pulse)
//   core_gnt      - core may drive the bus (level)
//   core_split    - transfer suspended, core must freeze (level)
//   core_resume   - pulse on re-ownership after a split
//   core_err      - pulse on request timeout
// Optional feature: define BUS_MASTER_TIMEOUT_EN to bound the REQ wait to
// TIMEOUT_CYCLES; otherwise REQ waits forever and core_err stays 0.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic m_grant,
  output logic m_req,
  output logic bus_util,
  input  logic core_req,
  input  logic core_done,
  output logic core_gnt,
  output logic core_split,
  output logic core_resume,
  output logic core_err
);

  bm_state_t state, state_d;
  logic      m_req_d, own_d, split_d, resume_d, err_d;
  logic      expire_c;

`ifdef BUS_MASTER_TIMEOUT_EN
  // Held clear outside REQ, so every entry to REQ starts from zero.
  bus_timeout_ctr #(
    .LIMIT (TIMEOUT_CYCLES),
    .CW    (CW)
  ) u_timeout_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (state != REQ),
    .en       ((state == REQ) && !m_grant),
    .expire_c (expire_c)
  );
`else
  logic unused_cfg;
  assign unused_cfg = ^CW'(TIMEOUT_CYCLES);
  assign expire_c   = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    err_d   = 1'b0;
    case (state)
      IDLE: begin
        if (core_req) state_d = REQ;
      end
      REQ: begin
        // A grant in the expiry cycle wins over the timeout.
        if (m_grant) begin
          state_d = OWN;
        end else if (expire_c) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (!core_req) begin
          state_d = IDLE;
        end
      end
      OWN: begin
        // Done takes priority: done with a simultaneous grant drop is completion.
        if (core_done) begin
          state_d = RELEASE;
        end else if (!m_grant) begin
          state_d = SPLIT;
        end
      end
      RELEASE: begin
        if (!m_grant) state_d = IDLE;
      end
      SPLIT: begin
        if (m_grant) state_d = OWN;
      end
      default: state_d = IDLE;
    endcase

    m_req_d  = (state_d == REQ) || (state_d == OWN);
    own_d    = (state_d == OWN);
    split_d  = (state_d == SPLIT);
    resume_d = (state == SPLIT) && (state_d == OWN);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      m_req       <= 1'b0;
      bus_util    <= 1'b0;
      core_gnt    <= 1'b0;
      core_split  <= 1'b0;
      core_resume <= 1'b0;
      core_err    <= 1'b0;
    end else begin
      state       <= state_d;
      m_req       <= m_req_d;
      bus_util    <= own_d;
      core_gnt    <= own_d;
      core_split  <= split_d;
      core_resume <= resume_d;
      core_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: a cycle table for the main flows plus
// hand sequences for lingering grant and request timeout.
module tb_bus_master_port;
  import bus_pkg::*;

  logic clk, rst, m_grant, m_req, bus_util, core_req, core_done;
  logic core_gnt, core_split, core_resume, core_err;

  int checks = 0;
  int errors = 0;

  bus_master_port #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .m_grant     (m_grant),
    .m_req       (m_req),
    .bus_util    (bus_util),
    .core_req    (core_req),
    .core_done   (core_done),
    .core_gnt    (core_gnt),
    .core_split  (core_split),
    .core_resume (core_resume),
    .core_err    (core_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp bits: {m_req, bus_util, core_gnt, core_split, core_resume, core_err}
  typedef struct {
    logic      rst;
    logic      req;
    logic      done;
    logic      grant;
    logic [5:0] exp;
    bm_state_t st;
    string     name;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic rq, input logic dn,
                              input logic g, input logic [5:0] e,
                              input bm_state_t s, input string n);
    vec_t v;
    v.rst = r; v.req = rq; v.done = dn; v.grant = g; v.exp = e; v.st = s; v.name = n;
    vecs.push_back(v);
  endfunction

  function automatic logic [5:0] outs();
    return {m_req, bus_util, core_gnt, core_split, core_resume, core_err};
  endfunction

  // Apply inputs for one cycle; outputs are sampled 1ns after the edge.
  task automatic step(input logic r, input logic rq, input logic dn, input logic g);
    rst = r; core_req = rq; core_done = dn; m_grant = g;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask

  task automatic chk_state(input string n, input bm_state_t exp);
    checks++;
    if (dut.state !== exp) begin
      errors++;
      $display("FAIL %s state: got %0d expected %0d", n, dut.state, exp);
    end
  endtask

  initial begin
    rst = 1'b1; core_req = 1'b0; core_done = 1'b0; m_grant = 1'b0;

    // reset
    add(1, 0, 0, 0, 6'b000000, IDLE,    "reset0");
    add(1, 0, 0, 0, 6'b000000, IDLE,    "reset1");
    // basic grant
    add(0, 1, 0, 0, 6'b100000, REQ,     "b_req");
    add(0, 1, 0, 0, 6'b100000, REQ,     "b_wait1");
    add(0, 1, 0, 0, 6'b100000, REQ,     "b_wait2");
    add(0, 1, 0, 1, 6'b111000, OWN,     "b_own");
    add(0, 1, 0, 1, 6'b111000, OWN,     "b_own_hold");
    add(0, 0, 1, 1, 6'b000000, RELEASE, "b_done");
    add(0, 0, 0, 1, 6'b000000, RELEASE, "b_rel_hold");
    add(0, 0, 0, 0, 6'b000000, IDLE,    "b_idle");
    // grant ignored in IDLE
    add(0, 0, 0, 1, 6'b000000, IDLE,    "idle_ign_grant");
    add(0, 0, 0, 0, 6'b000000, IDLE,    "idle_quiet");
    // request withdrawn before grant
    add(0, 1, 0, 0, 6'b100000, REQ,     "a_req");
    add(0, 0, 0, 0, 6'b000000, IDLE,    "req_abort");
    // split and resume
    add(0, 1, 0, 0, 6'b100000, REQ,     "s_req");
    add(0, 1, 0, 1, 6'b111000, OWN,     "s_own");
    add(0, 1, 0, 1, 6'b111000, OWN,     "s_own_hold");
    add(0, 1, 0, 0, 6'b000100, SPLIT,   "s_split");
    add(0, 0, 0, 0, 6'b000100, SPLIT,   "s_hold_noreq");
    add(0, 0, 1, 0, 6'b000100, SPLIT,   "s_hold_done_ign");
    add(0, 0, 0, 1, 6'b111010, OWN,     "s_resume");
    add(0, 0, 0, 1, 6'b111000, OWN,     "s_resume_end");
    add(0, 0, 1, 1, 6'b000000, RELEASE, "s_done");
    add(0, 0, 0, 0, 6'b000000, IDLE,    "s_idle");
    // done and grant drop together, done in first OWN cycle
    add(0, 1, 0, 0, 6'b100000, REQ,     "sim_req");
    add(0, 1, 0, 1, 6'b111000, OWN,     "sim_own");
    add(0, 0, 1, 0, 6'b000000, RELEASE, "sim_release");
    add(0, 0, 0, 0, 6'b000000, IDLE,    "sim_idle");
    // reset mid-ownership
    add(0, 1, 0, 0, 6'b100000, REQ,     "r_req");
    add(0, 1, 0, 1, 6'b111000, OWN,     "r_own");
    add(1, 1, 0, 1, 6'b000000, IDLE,    "rst_mid_own");
    add(0, 0, 0, 0, 6'b000000, IDLE,    "r_after");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].done, vecs[i].grant);
      chk(vecs[i].name, outs(), vecs[i].exp);
      chk_state(vecs[i].name, vecs[i].st);
    end

    // lingering grant after done with core_req still high
    step(0, 1, 0, 0); chk("l_req", outs(), 6'b100000);
    step(0, 1, 0, 1); chk("l_own", outs(), 6'b111000);
    step(0, 1, 1, 1); chk("l_done", outs(), 6'b000000);
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 0, 1); chk("l_linger", outs(), 6'b000000);
    end
    step(0, 1, 0, 0); chk("l_grant_fall", outs(), 6'b000000);
    step(0, 1, 0, 0); chk("l_rereq", outs(), 6'b100000);
    step(0, 0, 0, 0); chk("l_idle", outs(), 6'b000000);

`ifdef BUS_MASTER_TIMEOUT_EN
    // m_req rises in cycle 1, core_err in cycle 10, re-request in cycle 11
    for (int k = 0; k <= 10; k++) begin
      logic [5:0] e;
      step(0, 1, 0, 0);
      e = (k + 1 == 10) ? 6'b000001 : 6'b100000;
      chk("timeout", outs(), e);
    end
    step(0, 0, 0, 0); chk("t_idle", outs(), 6'b000000);
    // grant in the expiry cycle wins
    for (int k = 0; k <= 8; k++) begin
      step(0, 1, 0, 0);
    end
    chk("tg_pre", outs(), 6'b100000);
    step(0, 1, 0, 1); chk("tg_grant_wins", outs(), 6'b111000);
    step(0, 0, 1, 1); chk("tg_done", outs(), 6'b000000);
    step(0, 0, 0, 0); chk("tg_idle", outs(), 6'b000000);
`else
    for (int k = 0; k < 100; k++) begin
      step(0, 1, 0, 0); chk("no_timeout", outs(), 6'b100000);
    end
    step(0, 0, 0, 0); chk("nt_idle", outs(), 6'b000000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
